// File: rtl/cla_serial_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cla_decomposed / cla_serial_sequencer
//  Brief    : NBIT-wide carry-lookahead slice, split into a nonlinear
//             product-term bus and a linear XOR stage. A word-serial
//             controller runs that one slice over WIDTH/NBIT beats, LSB
//             slice first, and keeps the inter-beat carry in a register.
//  Revision : 1.0  initial release
// ============================================================================

module cla_decomposed #(
  parameter int NBIT = 4,
  parameter int NNL  = 56
) (
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            c_in,
  output logic [NBIT-1:0] s,
  output logic            c_out
);

  // Row i of the nonlinear bus holds the i+2 product terms of carry i+1.
  // The rows are packed as a triangle, so row i starts at i*(i+3)/2.
  localparam int NL_USED = NBIT * (NBIT + 3) / 2;

  if (NNL < NL_USED) begin : g_nnl_check
    $error("cla_decomposed: NNL is too small for NBIT");
  end

  logic [NBIT-1:0]    w_g;
  logic [NBIT-1:0]    w_p;
  logic [NL_USED-1:0] w_nl;
  logic [NBIT:0]      w_c;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_c[0] = c_in;

  for (genvar i = 0; i < NBIT; i++) begin : g_carry
    localparam int OFF = i * (i + 3) / 2;
    // Term 0: the carry-in propagated through every bit 0..i.
    assign w_nl[OFF] = (&w_p[i:0]) & c_in;
    // Terms 1..i: the generate of bit k-1 propagated through bits k..i.
    for (genvar k = 1; k <= i; k++) begin : g_term
      assign w_nl[OFF+k] = (&w_p[i:k]) & w_g[k-1];
    end
    // Last term: bit i generates its own carry.
    assign w_nl[OFF+i+1] = w_g[i];
    assign w_c[i+1]      = |w_nl[OFF +: i+2];
  end

  assign s     = w_p ^ w_c[NBIT-1:0];
  assign c_out = w_c[NBIT];

endmodule

module cla_serial_sequencer #(
  parameter int NBIT  = 4,
  parameter int NNL   = 56,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             busy
);

  localparam int NBEAT = WIDTH / NBIT;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  if ((WIDTH % NBIT) != 0 || NBEAT < 1) begin : g_width_check
    $error("cla_serial_sequencer: WIDTH must be a positive multiple of NBIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [BW-1:0]    r_beat;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;
  logic [NBIT-1:0]  w_add_s;
  logic             w_add_co;

  // The only adder: always fed the low slice of the shift registers and
  // the carry register, never the carry-in port.
  cla_decomposed #(
    .NBIT (NBIT),
    .NNL  (NNL)
  ) u_cla (
    .a     (r_a_sh[NBIT-1:0]),
    .b     (r_b_sh[NBIT-1:0]),
    .c_in  (r_carry),
    .s     (w_add_s),
    .c_out (w_add_co)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = rst_n;
        w_accept = in_valid & rst_n;
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        w_last = (r_beat == LAST_BEAT);
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-beat slice write-back and carry chaining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_carry <= 1'b0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s     <= '0;
      r_c_out <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= c_in;
      r_beat  <= '0;
    end else if (r_state == S_RUN) begin
      r_s[r_beat*NBIT +: NBIT] <= w_add_s;
      r_carry                  <= w_add_co;
      r_a_sh                   <= r_a_sh >> NBIT;
      r_b_sh                   <= r_b_sh >> NBIT;
      // The counter stops on the last beat so it never wraps.
      if (w_last) r_c_out <= w_add_co;
      else        r_beat  <= r_beat + 1'b1;
    end
  end

  assign s     = r_s;
  assign c_out = r_c_out;

endmodule

`default_nettype wire

// File: tb/tb_cla_serial_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_serial_sequencer
//  Brief    : Self-checking bench for a 16-bit (4 beats) and a 4-bit
//             (single beat) instance of the word-serial adder.
//  Revision : 1.0  initial release
// ============================================================================

module tb_cla_serial_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv, ir, ov, ordy, co, bsy, ci;
  logic [15:0] a, b, s;

  logic        iv4, ir4, ov4, ordy4, co4, bsy4, ci4;
  logic [3:0]  a4, b4, s4;

  int total = 0;
  int bad   = 0;

  cla_serial_sequencer #(.NBIT(4), .NNL(56), .WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .c_in(ci), .out_valid(ov), .out_ready(ordy), .s(s), .c_out(co), .busy(bsy)
  );

  cla_serial_sequencer #(.NBIT(4), .NNL(56), .WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .c_in(ci4), .out_valid(ov4), .out_ready(ordy4), .s(s4), .c_out(co4), .busy(bsy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {c_out,s} = a + b + c_in, plain unsigned arithmetic.
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {4'd0, c};
  endfunction

  task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic c);
    int n = 0;
    while (!ir && n < 20) begin step(); n++; end
    check("start16_ready", ir, 1);
    iv = 1'b1; a = x; b = y; ci = c;
    step();
    iv = 1'b0;
  endtask

  task automatic wait16(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    int n = 0;
    logic [16:0] e;
    e = ref16(x, y, c);
    while (!ov && n < 20) begin step(); n++; end
    check({tag, "_latency"}, n, 4);
    check({tag, "_s"}, s, e[15:0]);
    check({tag, "_cout"}, co, e[16]);
    check({tag, "_busy"}, bsy, 1);
    check({tag, "_inready"}, ir, 0);
  endtask

  task automatic release16(input string tag);
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    check({tag, "_rel_ov"}, ov, 0);
    check({tag, "_rel_ir"}, ir, 1);
  endtask

  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    start16(x, y, c);
    wait16(tag, x, y, c);
    release16(tag);
  endtask

  logic [4:0]  q4[$];
  logic [4:0]  e4;
  logic [15:0] s_hold;
  logic        c_hold;
  int          acc, got;

  initial begin
    rst_n = 1'b0;
    iv = 0; ordy = 0; a = '0; b = '0; ci = 0;
    iv4 = 0; ordy4 = 0; a4 = '0; b4 = '0; ci4 = 0;
    repeat (3) step();

    // Reset state
    check("rst_ir_forced", ir, 0);
    check("rst_ov", ov, 0);
    check("rst_busy", bsy, 0);
    check("rst_s", s, 0);
    check("rst_cout", co, 0);
    check("rst_ir4_forced", ir4, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ir", ir, 1);

    // Directed 16-bit cases
    op16("t1", 16'h00FF, 16'h0001, 1'b0);
    op16("t2", 16'hFFFF, 16'h0001, 1'b0);
    op16("t3", 16'h1234, 16'h4321, 1'b1);

    // Backpressure: DONE held, second operand offered but not taken
    start16(16'h8001, 16'h7FFF, 1'b1);
    wait16("t4a", 16'h8001, 16'h7FFF, 1'b1);
    s_hold = s; c_hold = co;
    iv = 1'b1; a = 16'h0F0F; b = 16'h0101; ci = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_s_stable", s, s_hold);
      check("t4_c_stable", co, c_hold);
      check("t4_ov_held", ov, 1);
      check("t4_ir_low", ir, 0);
    end
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    check("t4_idle_ov", ov, 0);
    check("t4_idle_ir", ir, 1);
    step();
    iv = 1'b0;
    check("t4_second_taken", bsy, 1);
    wait16("t4b", 16'h0F0F, 16'h0101, 1'b0);
    release16("t4b");

    // Reset while beat==2
    start16(16'hABCD, 16'h1111, 1'b0);
    step();
    step();
    check("t5_busy_run", bsy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("t5_ov", ov, 0);
    check("t5_ir", ir, 1);
    check("t5_busy", bsy, 0);
    op16("t5", 16'h0001, 16'h0001, 1'b0);

    // Random 16-bit operations
    for (int i = 0; i < 10; i++) begin
      op16("rand16", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Single-beat instance, directed
    begin
      int n = 0;
      check("t6_ir", ir4, 1);
      iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; ci4 = 1'b1;
      step();
      iv4 = 1'b0;
      while (!ov4 && n < 20) begin step(); n++; end
      check("t6_latency", n, 1);
      check("t6_s", s4, 4'h1);
      check("t6_cout", co4, 1);
      ordy4 = 1'b1;
      step();
      ordy4 = 1'b0;
      check("t6_rel_ov", ov4, 0);
    end

    // Single-beat instance, random traffic against a queue scoreboard
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      iv4   = ($urandom_range(0, 3) != 0);
      a4    = 4'($urandom);
      b4    = 4'($urandom);
      ci4   = 1'($urandom);
      ordy4 = ($urandom_range(0, 3) != 0);
      if (ov4 && ordy4) begin
        if (q4.size() == 0) check("rand4_unexpected", 1, 0);
        else begin
          e4 = q4.pop_front();
          check("rand4_sum", {co4, s4}, e4);
        end
        got++;
      end
      if (iv4 && ir4) begin
        q4.push_back(ref4(a4, b4, ci4));
        acc++;
      end
      step();
    end
    iv4 = 1'b0;
    ordy4 = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (ov4) begin
        if (q4.size() == 0) check("rand4_unexpected", 1, 0);
        else begin
          e4 = q4.pop_front();
          check("rand4_drain", {co4, s4}, e4);
        end
        got++;
      end
      step();
    end
    ordy4 = 1'b0;
    check("rand4_count", got, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
